// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Requester count is fixed at 8 because the select is 3 bits wide.
package rr_mux_arbiter_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating-priority encoder: first set bit of req searching ptr, ptr+1, ... mod 8.
// Purely combinational.
module rr_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int j = 0; j < N_REQ; j++) begin
      cand = ptr + SEL_W'(j);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 8:1 select datapath among 8 requesters,
// presenting the captured word on a valid/ready handshake with a one-cycle grant.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] din,
  output logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  logic              handshake;
  logic [N_REQ-1:0]  pick_req;
  logic [SEL_W-1:0]  pick_ptr;
  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;
  logic [DATA_W-1:0] pick_data;

  assign handshake = valid_q & out_ready;
  assign gnt       = onehot8(sel_q) & {N_REQ{handshake}};

  // In BUSY the search always starts just past the current winner and excludes it,
  // so a winner still holding req cannot be re-selected back to back.
  always_comb begin
    pick_req = req;
    pick_ptr = ptr_q;
    if (state_q == StBusy) begin
      pick_req = req & ~gnt;
      pick_ptr = sel_q + SEL_W'(1);
    end
  end

  rr_pick u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == SEL_W'(i)) begin
        pick_data = din[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          data_d  = pick_data;
          valid_d = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (handshake) begin
          ptr_d = sel_q + SEL_W'(1);
          if (pick_any) begin
            sel_d  = pick_idx;
            data_d = pick_data;
          end else begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == StBusy);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural round-robin model.
module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  req = '0;
  logic [63:0] din = '0;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [7:0]  gnt;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  rr_mux_arbiter #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .gnt       (gnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the pending word, who owns it, and where the next search starts.
  logic       m_valid = 1'b0;
  logic [2:0] m_sel   = '0;
  logic [2:0] m_ptr   = '0;
  logic [7:0] m_data  = '0;

  function automatic int first_from(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] slice_of(input logic [63:0] d, input int i);
    return d[i*8 +: 8];
  endfunction

  function automatic logic [7:0] others(input logic [7:0] r, input logic [2:0] s);
    return r & ~(8'd1 << s);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_sel   <= '0;
      m_ptr   <= '0;
      m_data  <= '0;
    end else if (!m_valid) begin
      if (req != 8'd0) begin
        m_valid <= 1'b1;
        m_sel   <= 3'(first_from(req, int'(m_ptr)));
        m_data  <= slice_of(din, first_from(req, int'(m_ptr)));
      end
    end else if (out_ready) begin
      m_ptr <= 3'((int'(m_sel) + 1) % 8);
      if (others(req, m_sel) != 8'd0) begin
        m_sel  <= 3'(first_from(others(req, m_sel), (int'(m_sel) + 1) % 8));
        m_data <= slice_of(din, first_from(others(req, m_sel), (int'(m_sel) + 1) % 8));
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_out_valid", 64'(out_valid), 64'(m_valid));
      check("m_busy", 64'(busy), 64'(m_valid));
      check("m_gnt", 64'(gnt), (m_valid && out_ready) ? 64'(8'd1 << m_sel) : 64'd0);
      if (m_valid) begin
        check("m_sel", 64'(sel), 64'(m_sel));
        check("m_out_data", 64'(out_data), 64'(m_data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_after_rst", 64'(out_valid), 64'd0);

    // Single request from requester 2
    req = 8'b0000_0100;
    din = '0;
    din[23:16] = 8'hA5;
    out_ready = 1'b1;
    step();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_sel", 64'(sel), 64'd2);
    check("single_data", 64'(out_data), 64'hA5);
    check("single_gnt", 64'(gnt), 64'h04);
    req = 8'd0;
    step();
    check("single_idle", 64'(out_valid), 64'd0);
    check("single_gnt_off", 64'(gnt), 64'd0);

    // ptr is now 3: requesters 0 and 3 pending, 3 wins first, then 0
    req = 8'h09;
    step();
    check("ptr3_sel", 64'(sel), 64'd3);
    check("ptr3_gnt", 64'(gnt), 64'h08);
    step();
    check("ptr3_next_sel", 64'(sel), 64'd0);
    check("ptr3_next_valid", 64'(out_valid), 64'd1);
    check("ptr3_next_gnt", 64'(gnt), 64'h01);
    req = 8'd0;
    step();
    check("ptr3_idle", 64'(out_valid), 64'd0);

    // Async reset in the middle of BUSY
    req = 8'h10;
    out_ready = 1'b0;
    step();
    check("midrst_cap_sel", 64'(sel), 64'd4);
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_sel", 64'(sel), 64'd0);
    check("midrst_gnt", 64'(gnt), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    req = 8'd0;
    step();
    rst_n = 1'b1;
    step();
    step();
    check("midrst_idle", 64'(out_valid), 64'd0);

    // Fairness with everyone requesting
    req = 8'hFF;
    for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'(8'h10 + i);
    step();
    for (int i = 0; i < 9; i++) begin
      check("fair_valid", 64'(out_valid), 64'd1);
      check("fair_sel", 64'(sel), 64'(i % 8));
      check("fair_gnt", 64'(gnt), 64'(8'd1 << (i % 8)));
      check("fair_data", 64'(out_data), 64'(8'h10 + (i % 8)));
      if (i == 8) req = 8'd0;
      step();
    end
    check("fair_idle", 64'(out_valid), 64'd0);

    // Backpressure: ptr is 1, requester 1 captured, then din churns
    req = 8'h02;
    din[15:8] = 8'h3C;
    out_ready = 1'b0;
    step();
    req = 8'd0;
    for (int i = 0; i < 5; i++) begin
      din = {$urandom, $urandom};
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_sel", 64'(sel), 64'd1);
      check("bp_data", 64'(out_data), 64'h3C);
      check("bp_gnt", 64'(gnt), 64'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_gnt", 64'(gnt), 64'h02);
    check("bp_release_data", 64'(out_data), 64'h3C);
    step();
    check("bp_idle", 64'(out_valid), 64'd0);

    // Wrap-around: ptr 2 -> grant 6, then 7 before 0
    req = 8'h40;
    step();
    check("wrap_sel6", 64'(sel), 64'd6);
    req = 8'h81;
    step();
    check("wrap_sel7", 64'(sel), 64'd7);
    check("wrap_gnt7", 64'(gnt), 64'h80);
    step();
    check("wrap_sel0", 64'(sel), 64'd0);
    check("wrap_gnt0", 64'(gnt), 64'h01);
    req = 8'd0;
    step();
    check("wrap_idle", 64'(out_valid), 64'd0);
    req = 8'h03;
    step();
    check("wrap_ptr1", 64'(sel), 64'd1);
    req = 8'd0;
    step();

    // Withdrawal: ptr 2, capture 3, drop req[3], pulse req[5] during BUSY only
    req = 8'h08;
    out_ready = 1'b0;
    din[31:24] = 8'h77;
    step();
    check("wd_sel", 64'(sel), 64'd3);
    req = 8'd0;
    step();
    req = 8'h20;
    step();
    req = 8'd0;
    step();
    out_ready = 1'b1;
    #1;
    check("wd_gnt", 64'(gnt), 64'h08);
    check("wd_data", 64'(out_data), 64'h77);
    step();
    check("wd_no_req5", 64'(out_valid), 64'd0);

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      req       = ($urandom % 3 == 0) ? 8'($urandom) : (8'd1 << ($urandom % 8)) & 8'($urandom);
      din       = {$urandom, $urandom};
      out_ready = ($urandom % 4) != 0;
      if (c % 731 == 500) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rand_rst_valid", 64'(out_valid), 64'd0);
        check("rand_rst_gnt", 64'(gnt), 64'd0);
        step();
        rst_n = 1'b1;
      end
      step();
    end

    out_ready = 1'b0;
    req = 8'd0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
